// File: rtl/instruction_fetch_sequencer.sv
// Front-end fetch sequencer: drives the I-cache address, tracks the in-flight word
// and hands instruction/PC pairs to decode under a valid/stall handshake.
module instruction_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  output logic [31:0] o_MemAddress,
  input  logic [31:0] i_MemData,
  input  logic        i_MemMisaligned,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectTarget,
  output logic        o_InstrValid,
  output logic [31:0] o_Instr,
  output logic [31:0] o_InstrPC,
  output logic        o_FetchFault
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_valid_q, inflight_valid_d;
  logic        inflight_mis_q, inflight_mis_d;

  logic out_live;
  logic hold;
  logic issue;

  always_comb begin
    // Reset gates the outputs directly so nothing stale leaks out during the reset cycle.
    out_live     = (state_q == RUN) && inflight_valid_q && !i_Redirect && !i_Reset;
    o_InstrValid = out_live && !inflight_mis_q;
    o_FetchFault = out_live && inflight_mis_q;
    o_Instr      = i_MemData;
    o_InstrPC    = inflight_pc_q;
    hold         = out_live && i_Stall;

    // While held, re-read the presented word so the cache data stays stable.
    if (i_Reset)         o_MemAddress = RESET_VECTOR;
    else if (i_Redirect) o_MemAddress = i_RedirectTarget;
    else if (hold)       o_MemAddress = inflight_pc_q;
    else                 o_MemAddress = fetch_pc_q;
  end

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_mis_d   = inflight_mis_q;
    issue            = 1'b0;

    if (i_Redirect) begin
      issue   = 1'b1;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (o_FetchFault && !i_Stall) begin
        state_d          = HALTED;
        inflight_valid_d = 1'b0;
      end else if (!hold) begin
        issue = 1'b1;
      end
    end

    if (issue) begin
      inflight_pc_d    = o_MemAddress;
      inflight_valid_d = 1'b1;
      inflight_mis_d   = i_MemMisaligned;
      fetch_pc_d       = o_MemAddress + 32'd4;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q          <= RUN;
      fetch_pc_q       <= RESET_VECTOR;
      inflight_pc_q    <= RESET_VECTOR;
      inflight_valid_q <= 1'b0;
      inflight_mis_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_mis_q   <= inflight_mis_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a one-cycle-latency cache
// model whose word at byte address A is A>>2.
module tb_instruction_fetch_sequencer;

  logic        clk;
  logic        i_Reset;
  logic [31:0] o_MemAddress;
  logic [31:0] mem_data_reg;
  logic        mem_mis;
  logic        i_Stall;
  logic        i_Redirect;
  logic [31:0] i_RedirectTarget;
  logic        o_InstrValid;
  logic [31:0] o_Instr;
  logic [31:0] o_InstrPC;
  logic        o_FetchFault;

  int vectors;
  int miscompares;
  int cycle_no;

  instruction_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .i_Clock          (clk),
    .i_Reset          (i_Reset),
    .o_MemAddress     (o_MemAddress),
    .i_MemData        (mem_data_reg),
    .i_MemMisaligned  (mem_mis),
    .i_Stall          (i_Stall),
    .i_Redirect       (i_Redirect),
    .i_RedirectTarget (i_RedirectTarget),
    .o_InstrValid     (o_InstrValid),
    .o_Instr          (o_Instr),
    .o_InstrPC        (o_InstrPC),
    .o_FetchFault     (o_FetchFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_mis = (o_MemAddress[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (i_Reset) mem_data_reg <= 32'h0;
    else         mem_data_reg <= {2'b00, o_MemAddress[31:2]};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle_no, got, exp);
    end
  endtask

  // Advance one cycle: drive inputs just after the edge, settle to mid-cycle for checks.
  task automatic cyc(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    i_Reset          = rst;
    i_Stall          = stall;
    i_Redirect       = redir;
    i_RedirectTarget = tgt;
    cycle_no++;
    #4;
    $display("cycle %0d rst=%0b stall=%0b redir=%0b addr=%h valid=%0b fault=%0b pc=%h instr=%h",
             cycle_no, rst, stall, redir, o_MemAddress, o_InstrValid, o_FetchFault, o_InstrPC, o_Instr);
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr);
    check_val("valid", {31'b0, o_InstrValid}, 32'd1);
    check_val("fault", {31'b0, o_FetchFault}, 32'd0);
    check_val("pc", o_InstrPC, pc);
    check_val("instr", o_Instr, instr);
  endtask

  task automatic expect_idle();
    check_val("valid_lo", {31'b0, o_InstrValid}, 32'd0);
    check_val("fault_lo", {31'b0, o_FetchFault}, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cycle_no = 0;
    i_Reset = 1'b1;
    i_Stall = 1'b0;
    i_Redirect = 1'b0;
    i_RedirectTarget = 32'h0;

    // Reset cycles
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    expect_idle();
    check_val("rst_addr", o_MemAddress, 32'h0);

    // Post-reset stream
    cyc(0, 0, 0, 32'h0);
    expect_idle();
    check_val("addr0", o_MemAddress, 32'h0);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h0, 32'h0);
    check_val("addr1", o_MemAddress, 32'h4);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h4, 32'h1);

    // Stall three cycles at PC 8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 32'h0);
      expect_instr(32'h8, 32'h2);
      check_val("stall_addr", o_MemAddress, 32'h8);
    end
    cyc(0, 0, 0, 32'h0); expect_instr(32'h8, 32'h2);
    check_val("release_addr", o_MemAddress, 32'hC);
    cyc(0, 1, 0, 32'h0); expect_instr(32'hC, 32'h3);

    // Redirect while stalled at PC 12
    cyc(0, 1, 1, 32'h100);
    expect_idle();
    check_val("redir_addr", o_MemAddress, 32'h100);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h100, 32'h40);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h104, 32'h41);

    // Misaligned redirect -> fault -> halt
    cyc(0, 0, 1, 32'h102);
    expect_idle();
    cyc(0, 1, 0, 32'h0);
    check_val("fault_hi", {31'b0, o_FetchFault}, 32'd1);
    check_val("fault_valid", {31'b0, o_InstrValid}, 32'd0);
    check_val("fault_pc", o_InstrPC, 32'h102);
    cyc(0, 0, 0, 32'h0);
    check_val("fault_held", {31'b0, o_FetchFault}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 32'h0);
      expect_idle();
    end
    check_val("halt_addr", o_MemAddress, 32'h106);
    cyc(0, 0, 1, 32'h200);
    expect_idle();
    check_val("resume_addr", o_MemAddress, 32'h200);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h200, 32'h80);

    // Address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    expect_idle();
    cyc(0, 0, 0, 32'h0); expect_instr(32'hFFFF_FFFC, 32'h3FFF_FFFF);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h0, 32'h0);

    // Reset during a stall at PC 0x40
    cyc(0, 0, 1, 32'h40);
    cyc(0, 1, 0, 32'h0); expect_instr(32'h40, 32'h10);
    cyc(1, 1, 0, 32'h0);
    expect_idle();
    check_val("rst_mid_addr", o_MemAddress, 32'h0);
    cyc(0, 0, 0, 32'h0);
    expect_idle();
    check_val("restart_addr", o_MemAddress, 32'h0);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h0, 32'h0);
    cyc(0, 0, 0, 32'h0); expect_instr(32'h4, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
